pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 23 ++
 rtl/pc_fetch_unit_pc_register.sv | 31 +++
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and helpers for the PC fetch unit.
package pc_fetch_unit_pkg;

  localparam int XLEN   = 32;  // data/address width
  localparam int JUMP_W = 26;  // J/JAL instruction-index field width

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  // Source selected for the next PC
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JR     = 2'd3
  } pc_sel_e;

  // Instruction addresses are always word aligned
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_register.sv
// Program counter register: 32-bit, load enable, async active-low reset.
module pc_register
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VAL = DEFAULT_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Hold unless a load is requested
  always_comb begin
    pc_d = pc_q;
    if (load_i) pc_d = d_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pc_q <= RESET_VAL;
    else        pc_q <= pc_d;
  end

  assign q_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: next-PC selection, PC register and IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [XLEN-1:0]   branch_addr_i,
  input  logic              jump_i,
  input  logic [JUMP_W-1:0] jump_target_i,
  input  logic              jr_i,
  input  logic [XLEN-1:0]   jr_addr_i,
  input  logic [XLEN-1:0]   instr_i,
  output logic [XLEN-1:0]   pc_addr_o,
  output logic [XLEN-1:0]   ifid_instr_o,
  output logic [XLEN-1:0]   ifid_pc4_o,
  output logic              ifid_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]   fetch_cnt_o,
  output logic [XLEN-1:0]   stall_cnt_o
`endif
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            advance;
  pc_sel_e         pc_sel;

  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;

  // PC+4 wraps naturally in 32-bit arithmetic
  assign pc4      = pc + 32'd4;
  assign redirect = jr_i | branch_taken_i | jump_i;
  // A plain sequential fetch happens only with no redirect and no stall
  assign advance  = !redirect && !stall_i;

  // Next-PC priority: JR, then branch, then jump, then sequential
  always_comb begin
    pc_sel = SEL_SEQ;
    if (jr_i)                pc_sel = SEL_JR;
    else if (branch_taken_i) pc_sel = SEL_BRANCH;
    else if (jump_i)         pc_sel = SEL_JUMP;
    case (pc_sel)
      SEL_JR:     next_pc = align_word(jr_addr_i);
      SEL_BRANCH: next_pc = align_word(branch_addr_i);
      SEL_JUMP:   next_pc = {pc4[31:28], jump_target_i, 2'b00};
      default:    next_pc = pc4;
    endcase
  end

  // Redirect overrides stall; stall alone freezes the PC
  pc_register #(.RESET_VAL(RESET_PC)) u_pc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (redirect | !stall_i),
    .d_i    (next_pc),
    .q_o    (pc)
  );

  // IF/ID next state: flush on redirect, capture on advance, else hold
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (!stall_i) begin
      ifid_instr_d = instr_i;
      ifid_pc4_d   = pc4;
      ifid_valid_d = 1'b1;
    end
  end

  // IF/ID register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign pc_addr_o    = pc;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_valid_o = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters: sequential fetches and pure stall cycles
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (advance && fetch_cnt_q != '1)                 fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (!redirect && stall_i && stall_cnt_q != '1)    stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule
